sampler_readout: RTL and testbench



---
 rtl/sampler_pkg.sv | 34 +++
 rtl/sampler_cksum.sv | 37 +++
 rtl/sampler_readout.sv | 173 +++++++++++++++++
 tb/tb_sampler_readout.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sampler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sampler_pkg
// Purpose  : Shared definitions for the GPS 1-bit sample read-out path:
//            sequencer state encoding, default buffer depth and the derived
//            word count / word-counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sampler_pkg;

  // log2 of the sample buffer depth in bits
  localparam int SMP_DEPTH_LOG2 = 16;

  // 16-bit words per capture and the width of a counter that indexes them
  localparam int NWORDS = 2 ** (SMP_DEPTH_LOG2 - 4);
  localparam int WCNT_W = SMP_DEPTH_LOG2 - 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_STREAM  = 3'd4,
    ST_CKSUM   = 3'd5
  } state_t;

  // Words per capture for an arbitrary buffer depth
  function automatic int nwords(input int depth_log2);
    return 2 ** (depth_log2 - 4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sampler_cksum.sv
`default_nettype none
// ============================================================================
// Module   : sampler_cksum
// Purpose  : 16-bit modulo-2^16 accumulator of streamed buffer words.
// Ports    : clk   - system clock
//            rst_n - asynchronous active-low reset
//            clr   - synchronous clear of the running sum
//            en    - add din to the running sum this cycle
//            din   - word to accumulate
//            sum   - current running sum
// Revision : 1.0 - initial release
// ============================================================================
module sampler_cksum (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] sum
);

  logic [15:0] r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= 16'd0;
    end else if (clr) begin
      r_sum <= 16'd0;
    end else if (en) begin
      r_sum <= r_sum + din;
    end
  end

  assign sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/sampler_readout.sv
`default_nettype none
// ============================================================================
// Module   : sampler_readout
// Purpose  : Capture sequencer and read-out streamer for the 1-bit sample
//            buffer. A start pulse clears the buffer, times one capture of
//            2^DEPTH_LOG2 samples, then drains the buffer as 16-bit words on
//            a valid/ready stream.
// Config   : SAMPLER_READOUT_CKSUM_EN - when defined, a 16-bit sum of all
//            streamed words is appended as one extra word carrying out_last.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            start, abort        - begin capture / return to IDLE
//            smp_rst, smp_rd     - buffer synchronous reset, read advance
//            smp_dout            - buffer word at the read pointer
//            out_data/valid/ready/last - read-out stream
//            busy, done          - activity flag, end-of-capture pulse
// Revision : 1.0 - initial release
// ============================================================================
module sampler_readout
  import sampler_pkg::*;
#(
  parameter int DEPTH_LOG2 = SMP_DEPTH_LOG2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        smp_rst,
  output logic        smp_rd,
  input  logic [15:0] smp_dout,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int NW  = nwords(DEPTH_LOG2);
  localparam int WCW = DEPTH_LOG2 - 4;
  localparam int CCW = DEPTH_LOG2 + 1;

  localparam logic [CCW-1:0] CAP_LAST  = CCW'((1 << DEPTH_LOG2) - 1);
  localparam logic [WCW-1:0] WCNT_LAST = WCW'(NW - 1);

  state_t         r_state;
  state_t         w_next;
  logic [CCW-1:0] r_ccnt;
  logic [WCW-1:0] r_wcnt;
  logic           r_done;
  logic           w_final;   // the transfer that ends the capture happens now

`ifdef SAMPLER_READOUT_CKSUM_EN
  logic [15:0] w_sum;

  sampler_cksum u_cksum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (r_state == ST_CLEAR),
    .en    (smp_rd),
    .din   (smp_dout),
    .sum   (w_sum)
  );
`endif

  // --------------------------------------------------------------------------
  // State register and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ccnt  <= '0;
      r_wcnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_final;

      if (r_state == ST_CAPTURE) begin
        r_ccnt <= r_ccnt + 1'b1;
      end else begin
        r_ccnt <= '0;
      end

      // Leaving STREAM happens on the last transfer, so the counter never
      // needs to wrap.
      if (r_state != ST_STREAM) begin
        r_wcnt <= '0;
      end else if (smp_rd) begin
        r_wcnt <= r_wcnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    smp_rst   = 1'b0;
    smp_rd    = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = smp_dout;
    w_final   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        smp_rst = 1'b1;
        if (start) begin
          w_next = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        smp_rst = 1'b1;
        w_next  = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        if (r_ccnt == CAP_LAST) begin
          w_next = ST_SETTLE;
        end
      end

      // Buffer output is registered: one cycle for word 0 to appear.
      ST_SETTLE: begin
        w_next = ST_STREAM;
      end

      ST_STREAM: begin
        out_valid = 1'b1;
        smp_rd    = out_ready & ~abort;
        if (smp_rd && (r_wcnt == WCNT_LAST)) begin
`ifdef SAMPLER_READOUT_CKSUM_EN
          w_next = ST_CKSUM;
`else
          w_next  = ST_IDLE;
          w_final = 1'b1;
`endif
        end
`ifndef SAMPLER_READOUT_CKSUM_EN
        out_last = (r_wcnt == WCNT_LAST);
`endif
      end

`ifdef SAMPLER_READOUT_CKSUM_EN
      ST_CKSUM: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = w_sum;
        if (out_ready && !abort) begin
          w_next  = ST_IDLE;
          w_final = 1'b1;
        end
      end
`endif

      default: begin
        w_next = ST_IDLE;
      end
    endcase

    // Abort overrides everything, including a same-cycle start in IDLE.
    if (abort) begin
      w_next = ST_IDLE;
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sampler_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_sampler_readout
// Purpose  : Self-checking bench for sampler_readout at DEPTH_LOG2=8
//            (16 words per capture) with a registered sample-buffer model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sampler_readout;

  localparam int D  = 8;
  localparam int NW = 16;
`ifdef SAMPLER_READOUT_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int FIRST_VALID = (1 << D) + 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        smp_rst;
  logic        smp_rd;
  logic [15:0] smp_dout;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  sampler_readout #(.DEPTH_LOG2(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .smp_rst   (smp_rst),
    .smp_rd    (smp_rd),
    .smp_dout  (smp_dout),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // Registered sample-buffer model: reset zeroes the read pointer, a read
  // advances it, and dout shows the addressed word one cycle later.
  logic [15:0] mem [NW];
  logic [3:0]  ptr;
  logic [3:0]  baddr;
  logic [15:0] bdout;

  always_comb baddr = smp_rst ? 4'd0 : (smp_rd ? ptr + 4'd1 : ptr);

  always_ff @(posedge clk) begin
    ptr   <= baddr;
    bdout <= mem[baddr];
  end

  assign smp_dout = bdout;

  typedef struct {
    logic [15:0] d;
    bit          last;
    bit          ck;
  } exp_t;

  typedef struct {
    logic [15:0] base;
    logic [15:0] step;
    int          mode;      // 0 ready high, 1 toggle, 2 random
    int          abort_at;  // abort while this word index is presented
    int          rst_at;    // pull rst_n while this word index is presented
    bit          glitch;    // pulse start during CAPTURE
  } vec_t;

  exp_t        q[$];
  vec_t        tbl[7];
  int          checks;
  int          failures;
  int          cyc_n;
  int          acc_cnt;
  int          rd_seen;
  int          done_cnt;
  int          done_cyc;
  bit          prev_stall;
  logic [15:0] prev_data;
  bit          exp_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc_n);
    end
  endtask

  // Per-cycle stream monitor, sampled on the falling edge.
  task automatic mon();
    bit   acc;
    exp_t e;
    acc = out_valid && out_ready && !abort;
    if (prev_stall && out_valid) chk("stall_hold", out_data, prev_data);
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    chk("done", done, exp_done);
    if (done) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
    exp_done = 1'b0;
    if (acc) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_word actual=0x%0h required=none", out_data);
      end else begin
        e = q.pop_front();
        chk("word_data", out_data, e.d);
        chk("word_last", out_last, e.last);
        chk("rd_on_accept", smp_rd, !e.ck);
        exp_done = e.last;
      end
      acc_cnt++;
    end else begin
      chk("rd_idle", smp_rd, 1'b0);
    end
    rd_seen += int'(smp_rd);
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic run(input vec_t v);
    logic [15:0] w;
    logic [15:0] sum;
    bit          stop;
    int          first;
    q.delete();
    sum = 16'd0;
    w   = v.base;
    for (int i = 0; i < NW; i++) begin
      mem[i] = w;
      q.push_back('{w, (!CK && i == NW - 1), 1'b0});
      sum = sum + w;
      w   = w + v.step;
    end
    if (CK) q.push_back('{sum, 1'b1, 1'b1});

    acc_cnt  = 0;
    rd_seen  = 0;
    done_cnt = 0;
    done_cyc = -1;
    first    = -1;
    cyc_n    = 0;
    stop     = 1'b0;

    start     = 1'b1;
    out_ready = 1'b1;
    cyc();
    start = 1'b0;
    chk("busy_cycle1", busy, 1'b1);

    for (int n = 0; n < 2000 && !stop; n++) begin
      case (v.mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      if (v.glitch && cyc_n == 100) start = 1'b1;
      if (cyc_n == 2) chk("capture_rst_low", smp_rst, 1'b0);
      if (out_valid && first < 0) first = cyc_n;
      if (v.rst_at >= 0 && out_valid && acc_cnt == v.rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_smp_rst", smp_rst, 1'b1);
        chk("rst_smp_rd", smp_rd, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_data", out_data, smp_dout);
        stop = 1'b1;
      end else begin
        if (v.abort_at >= 0 && out_valid && acc_cnt == v.abort_at) abort = 1'b1;
        cyc();
        start = 1'b0;
        if (abort) begin
          abort = 1'b0;
          chk("abort_valid", out_valid, 1'b0);
          chk("abort_smp_rst", smp_rst, 1'b1);
          chk("abort_busy", busy, 1'b0);
          stop = 1'b1;
        end else if (done_cnt > 0) begin
          stop = 1'b1;
        end
      end
    end

    if (!stop) begin
      checks++;
      failures++;
      $display("FAIL run_timeout actual=no_end required=done_or_abort");
    end
    chk("first_valid_cycle", first, FIRST_VALID);

    if (v.rst_at >= 0) begin
      q.delete();
      cyc();
      cyc();
      prev_stall = 1'b0;
      exp_done   = 1'b0;
      rst_n      = 1'b1;
      cyc();
      chk("post_rst_busy", busy, 1'b0);
    end else if (v.abort_at >= 0) begin
      q.delete();
      for (int k = 0; k < 3; k++) cyc();
      chk("abort_no_done", done_cnt, 0);
      chk("abort_rd_count", rd_seen, v.abort_at);
      chk("abort_idle", busy, 1'b0);
    end else begin
      cyc();
      chk("queue_drained", q.size(), 0);
      chk("rd_pulses", rd_seen, NW);
      chk("done_count", done_cnt, 1);
      if (v.mode == 0) chk("done_cycle", done_cyc, FIRST_VALID + NW + int'(CK));
    end
  endtask

  initial begin
    tbl[0] = '{16'hA5A5, 16'h0000, 0, -1, -1, 1'b0};
    tbl[1] = '{16'h0001, 16'h0001, 0, -1, -1, 1'b0};
    tbl[2] = '{16'h0001, 16'h0001, 1, -1, -1, 1'b0};
    tbl[3] = '{16'h3C00, 16'h0111, 0,  7, -1, 1'b0};
    tbl[4] = '{16'hF000, 16'h1001, 0, -1, -1, 1'b1};
    tbl[5] = '{16'h8000, 16'h0FFF, 2, -1, -1, 1'b0};
    tbl[6] = '{16'h1234, 16'h0001, 1, -1,  5, 1'b0};

    checks     = 0;
    failures   = 0;
    cyc_n      = 0;
    prev_stall = 1'b0;
    prev_data  = 16'd0;
    exp_done   = 1'b0;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    out_ready  = 1'b0;
    for (int i = 0; i < NW; i++) mem[i] = 16'h5A00 + 16'(i);

    cyc();
    cyc();
    chk("reset_smp_rst", smp_rst, 1'b1);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_last", out_last, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_data", out_data, smp_dout);
    rst_n = 1'b1;
    cyc();

    // start together with abort in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 1'b0);
    for (int k = 0; k < 3; k++) cyc();
    chk("start_abort_still_idle", busy, 1'b0);
    chk("start_abort_smp_rst", smp_rst, 1'b1);

    for (int r = 0; r < 7; r++) begin
      run(tbl[r]);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
